cb_row_param: RTL
=================

CB_ROW_PARAM -- requirements
Module: cb_row_param

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 8: connection cells in the row, range 2..32.
REQ-002 SHALL have parameter CH_W, default 4: bits per cell side, range 1..16.
REQ-003 SHALL have parameter ODD_ROW, default 1: 1 = bit-reversed inter-cell links and reversed in4/out4 slice order; 0 = straight links and ascending slices.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clb_clk  input  1  single clock for the datapath and configuration logic; one clock, no separate programming clock.
- rst_n  input  1  reset, asynchronous, active-low.
- prog_in  input  1  serial configuration bit.
- prog_en  input  1  shift enable; high = frame in progress.
- prog_out  output  1  serial chain tail, for daisy-chaining rows.
- cfg_done  output  1  one-cycle pulse on a good commit.
- cfg_err  output  1  sticky frame-length error flag.
- in1  input  CH_W  west edge input.
- in2  input  NUM_CELLS*CH_W  north inputs.
- in3  input  CH_W  east edge input.
- in4  input  NUM_CELLS*CH_W  south inputs.
- out1  output  CH_W  west edge output.
- out2  output  NUM_CELLS*CH_W  north outputs.
- out3  output  CH_W  east edge output.
- out4  output  NUM_CELLS*CH_W  south outputs.

Function
REQ-005 Each cell SHALL have four sides: W, N, E, S, with CFG_CELL = 8*CH_W config bits and TOTAL_BITS = NUM_CELLS*CFG_CELL.
REQ-006 Cell i SHALL use the following sides and slices:
- N = in2/out2 slice [i*CH_W +: CH_W].
- S = in4/out4 slice [(NUM_CELLS-1-i)*CH_W +: CH_W] when ODD_ROW = 1, else slice [i*CH_W +: CH_W].
- Edge ports: cell 0 W = in1/out1; cell NUM_CELLS-1 E = in3/out3.
REQ-007 Cell i E input SHALL be cell i+1 W output, and cell i+1 W input SHALL be cell i E output, each bit-reversed when ODD_ROW = 1.
REQ-008 Each output bit b of each side SHALL use a 2-bit select and SHALL be registered:
- 00 = 0.
- 01, 10, 11 = bit b of the other three sides, in ascending W, N, E, S order with the own side excluded.
- Each hop therefore has 1 clb_clk latency, which breaks all routing loops.
REQ-009 Cell config layout SHALL be: out W sel [2*CH_W-1:0], then N, E, S, with bit b select at [2b+1:2b] within its side.
REQ-010 The shadow chain SHALL be TOTAL_BITS long:
- When shifting, prog_in enters bit 0 and all bits move up one place.
- prog_out = shadow[TOTAL_BITS-1].
- Cell i config = shadow[i*CFG_CELL +: CFG_CELL].
REQ-011 The FSM SHALL have states IDLE, SHIFT, COMMIT, ERR.
- IDLE to SHIFT on prog_en = 1, and that cycle's bit is shifted.
- In SHIFT, while prog_en = 1: shift and increment the bit counter. The counter is wide enough for TOTAL_BITS+1 and saturates there.
- SHIFT on prog_en = 0 goes to COMMIT if count == TOTAL_BITS, else to ERR.
- COMMIT: the active config takes the shadow atomically, cfg_done = 1 for one cycle, cfg_err is cleared, then IDLE.
- ERR: active config unchanged, cfg_err set, then IDLE.
- The counter clears on return to IDLE.
REQ-012 Routing SHALL continue with the old active config throughout a shift, and the new config SHALL take effect on the cycle after COMMIT.
REQ-013 cfg_err SHALL remain set until the next good commit or reset.

Reset
REQ-014 rst_n low SHALL asynchronously clear the following, and the FSM SHALL go to IDLE:
- Shadow and active config.
- Output registers: all data outputs become 0.
- Counter.
- cfg_done, cfg_err and prog_out (all 0).
REQ-015 Reset during SHIFT SHALL discard the partial frame: no commit and no error.

Structure
REQ-016 Package cb_pkg SHALL hold the select encodings (SEL_ZERO, SEL_A, SEL_B, SEL_C), the FSM state typedef, and the CFG_CELL width function.
REQ-017 Per-cell routing and output registers SHALL be one sub-module, cb_row_cell, generated NUM_CELLS times. The chain, FSM and counter SHALL live in the top level.

Verification
REQ-018 The bench SHALL cover the following directed scenarios (default parameters):
- Reset check: assert rst_n low mid-cycle -> all outputs 0 immediately; cfg_done = 0 and cfg_err = 0.
- East pass-through: load 256 bits setting every cell E sel = 01 (W), then in1 = 4'hA -> out3 = 4'h5 exactly 8 cycles later. With ODD_ROW = 0 the same test gives out3 = 4'hA.
- Short frame: 255 bits then prog_en low -> cfg_err = 1, no cfg_done, and routing is unchanged from the prior config.
- Long frame of 300 bits: prog_out equals prog_in delayed 256 cycles; cfg_err = 1 at end.
- South-to-north: cell 3 N sel = 11 (S), in4[19:16] = 4'h6 (ODD_ROW = 1) -> out2[15:12] = 4'h6 after 1 cycle.
- Reset mid-frame: rst_n low after 100 bits -> no cfg_done, cfg_err = 0, outputs 0; a following full 256-bit frame commits normally.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared definitions for the connection-box row: routing select codes,
// configuration FSM states and the per-cell configuration width.
package cb_pkg;

   // Two-bit output select: zero, or one of the three other sides taken in
   // ascending W, N, E, S order with the driven side itself skipped.
   typedef enum logic [1:0] {
      SEL_ZERO = 2'b00,
      SEL_A    = 2'b01,
      SEL_B    = 2'b10,
      SEL_C    = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      COMMIT = 2'b10,
      ERR    = 2'b11
   } state_e;

   // Side indices used inside a cell.
   localparam int SIDE_W = 0;
   localparam int SIDE_N = 1;
   localparam int SIDE_E = 2;
   localparam int SIDE_S = 3;

   // Four sides, CH_W output bits each, two select bits per output bit.
   function automatic int cfg_cell_w(input int ch_w);
      return 8 * ch_w;
   endfunction

endpackage

// File: rtl/cb_row_cell.sv
// One connection cell: every output bit of every side picks bit b of one of
// the other three sides (or zero) and registers it, so each hop costs one
// clock and no combinational loop can form through the row.
module cb_row_cell
   import cb_pkg::*;
#(
   parameter int CH_W = 4
) (
   input  logic                        clb_clk,
   input  logic                        rst_n,
   input  logic [cfg_cell_w(CH_W)-1:0] i_cfg,
   input  logic [CH_W-1:0]             i_w,
   input  logic [CH_W-1:0]             i_n,
   input  logic [CH_W-1:0]             i_e,
   input  logic [CH_W-1:0]             i_s,
   output logic [CH_W-1:0]             o_w,
   output logic [CH_W-1:0]             o_n,
   output logic [CH_W-1:0]             o_e,
   output logic [CH_W-1:0]             o_s
);

   logic [CH_W-1:0] w_side_in [4];
   logic [CH_W-1:0] w_next    [4];
   logic [CH_W-1:0] r_out     [4];

   // Gather the four side inputs so the select logic can index them.
   always_comb begin
      w_side_in[SIDE_W] = i_w;
      w_side_in[SIDE_N] = i_n;
      w_side_in[SIDE_E] = i_e;
      w_side_in[SIDE_S] = i_s;
   end

   // Per-bit select: code k (1..3) maps to the k-th other side, skipping self.
   always_comb begin : sel_mux
      logic [1:0] sel;
      int         src;
      // NOTE: every output gets a default before any branch so no latch is inferred.
      sel = SEL_ZERO;
      src = 0;
      for (int s = 0; s < 4; s++) begin
         w_next[s] = '0;
         for (int b = 0; b < CH_W; b++) begin
            sel = i_cfg[(s * CH_W + b) * 2 +: 2];
            if (sel != SEL_ZERO) begin
               src = int'(sel) - 1;
               if (src >= s) src = src + 1;
               w_next[s][b] = w_side_in[src][b];
            end
         end
      end
   end

   // Output registers: one clock of latency per hop.
   always_ff @(posedge clb_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '{default: '0};
      end else begin
         // NOTE: state is updated with <= so all registers sample the same pre-edge values.
         r_out <= w_next;
      end
   end

   assign o_w = r_out[SIDE_W];
   assign o_n = r_out[SIDE_N];
   assign o_e = r_out[SIDE_E];
   assign o_s = r_out[SIDE_S];

endmodule

// File: rtl/cb_row_param.sv
// Connection-box row: NUM_CELLS routing cells chained west-to-east, loaded
// through a serial shadow chain and committed atomically by a small FSM.
module cb_row_param
   import cb_pkg::*;
#(
   parameter int NUM_CELLS = 8,
   parameter int CH_W      = 4,
   parameter int ODD_ROW   = 1
) (
   input  logic                      clb_clk,
   input  logic                      rst_n,
   input  logic                      prog_in,
   input  logic                      prog_en,
   output logic                      prog_out,
   output logic                      cfg_done,
   output logic                      cfg_err,
   input  logic [CH_W-1:0]           in1,
   input  logic [NUM_CELLS*CH_W-1:0] in2,
   input  logic [CH_W-1:0]           in3,
   input  logic [NUM_CELLS*CH_W-1:0] in4,
   output logic [CH_W-1:0]           out1,
   output logic [NUM_CELLS*CH_W-1:0] out2,
   output logic [CH_W-1:0]           out3,
   output logic [NUM_CELLS*CH_W-1:0] out4
);

   localparam int CFG_CELL   = cfg_cell_w(CH_W);
   localparam int TOTAL_BITS = NUM_CELLS * CFG_CELL;
   localparam int CNT_W      = $clog2(TOTAL_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL_BITS + 1);

   state_e                r_state;
   state_e                w_next_state;
   logic                  w_shift;
   logic                  w_commit;
   logic                  w_err_set;
   logic [TOTAL_BITS-1:0] r_shadow;
   logic [TOTAL_BITS-1:0] r_active;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_err;

   // Odd rows cross-wire neighbouring cells bit-reversed.
   function automatic logic [CH_W-1:0] link(input logic [CH_W-1:0] v);
      for (int b = 0; b < CH_W; b++) begin
         link[b] = (ODD_ROW != 0) ? v[CH_W-1-b] : v[b];
      end
   endfunction

   // Next-state and control decode for the configuration FSM.
   always_comb begin
      w_next_state = r_state;
      w_shift      = 1'b0;
      w_commit     = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         IDLE: begin
            if (prog_en) begin
               w_shift      = 1'b1;
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (prog_en)                w_shift      = 1'b1;
            else if (r_cnt == CNT_FULL) w_next_state = COMMIT;
            else                        w_next_state = ERR;
         end
         COMMIT: begin
            w_commit     = 1'b1;
            w_next_state = IDLE;
         end
         ERR: begin
            w_err_set    = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // FSM state register; reset mid-frame simply drops back to IDLE.
   always_ff @(posedge clb_clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Shadow chain: new bit enters at 0, tail feeds the next row.
   always_ff @(posedge clb_clk or negedge rst_n) begin
      // NOTE: configuration storage is plain flops, so it is reset to a known all-zero routing.
      if (!rst_n)       r_shadow <= '0;
      else if (w_shift) r_shadow <= {r_shadow[TOTAL_BITS-2:0], prog_in};
   end

   // Frame bit counter, saturating one past a full frame, cleared on leaving.
   always_ff @(posedge clb_clk or negedge rst_n) begin
      if (!rst_n)                                r_cnt <= '0;
      else if (w_commit || w_err_set)            r_cnt <= '0;
      else if (w_shift && (r_cnt != CNT_SAT))    r_cnt <= r_cnt + CNT_W'(1);
   end

   // Active config swap and sticky error flag.
   always_ff @(posedge clb_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= '0;
         r_err    <= 1'b0;
      end else if (w_commit) begin
         r_active <= r_shadow;
         r_err    <= 1'b0;
      end else if (w_err_set) begin
         r_err    <= 1'b1;
      end
   end

   assign prog_out = r_shadow[TOTAL_BITS-1];
   assign cfg_done = w_commit;
   assign cfg_err  = r_err;

   logic [CH_W-1:0] w_w_in  [NUM_CELLS];
   logic [CH_W-1:0] w_w_out [NUM_CELLS];
   logic [CH_W-1:0] w_e_in  [NUM_CELLS];
   logic [CH_W-1:0] w_e_out [NUM_CELLS];

   assign w_w_in[0]           = in1;
   assign out1                = w_w_out[0];
   assign w_e_in[NUM_CELLS-1] = in3;
   assign out3                = w_e_out[NUM_CELLS-1];

   for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
      localparam int S_IDX = (ODD_ROW != 0) ? (NUM_CELLS - 1 - i) : i;

      if (i < NUM_CELLS - 1) begin : g_link
         assign w_e_in[i]   = link(w_w_out[i+1]);
         assign w_w_in[i+1] = link(w_e_out[i]);
      end

      cb_row_cell #(.CH_W(CH_W)) u_cell (
         .clb_clk (clb_clk),
         .rst_n   (rst_n),
         .i_cfg   (r_active[i*CFG_CELL +: CFG_CELL]),
         .i_w     (w_w_in[i]),
         .i_n     (in2[i*CH_W +: CH_W]),
         .i_e     (w_e_in[i]),
         .i_s     (in4[S_IDX*CH_W +: CH_W]),
         .o_w     (w_w_out[i]),
         .o_n     (out2[i*CH_W +: CH_W]),
         .o_e     (w_e_out[i]),
         .o_s     (out4[S_IDX*CH_W +: CH_W])
      );
   end

endmodule
